// File: rtl/bip2_core.sv
// Single-cycle Harvard accumulator processor: one instruction completes per rising edge.
// PC, ACC and the {Z, N} status flags are the only architectural state.
module bip2_core #(
    parameter int OPERAND_ADDRESS_WIDTH  = 11,
    parameter int INSTRUCTION_DATA_WIDTH = 16
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] instruction_in,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] data_in,
    output logic [OPERAND_ADDRESS_WIDTH-1:0]  instruction_address_out,
    output logic [OPERAND_ADDRESS_WIDTH-1:0]  data_address_out,
    output logic [INSTRUCTION_DATA_WIDTH-1:0] data_out,
    output logic                              data_wr_out
);

    localparam int OAW   = OPERAND_ADDRESS_WIDTH;
    localparam int IDW   = INSTRUCTION_DATA_WIDTH;
    localparam int OPC_W = IDW - OAW;

    localparam logic [OPC_W-1:0] OP_HLT  = OPC_W'(0);
    localparam logic [OPC_W-1:0] OP_STO  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_SUBI = OPC_W'(7);
    localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(8);
    localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(9);
    localparam logic [OPC_W-1:0] OP_BGT  = OPC_W'(10);
    localparam logic [OPC_W-1:0] OP_BGE  = OPC_W'(11);
    localparam logic [OPC_W-1:0] OP_BLT  = OPC_W'(12);
    localparam logic [OPC_W-1:0] OP_BLE  = OPC_W'(13);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(14);

    logic        [OAW-1:0]   pc_q;
    logic signed [IDW-1:0]   acc_q;
    logic                    z_q;
    logic                    n_q;

    logic        [OAW-1:0]   pc_nxt;
    logic signed [IDW-1:0]   acc_nxt;
    logic                    z_nxt;
    logic                    n_nxt;

    logic        [OPC_W-1:0] opcode;
    logic        [OAW-1:0]   operand;
    logic signed [IDW-1:0]   imm;
    logic signed [IDW-1:0]   mem_val;
    logic signed [IDW-1:0]   alu_res;
    logic                    alu_op;

    function automatic logic signed [IDW-1:0] sign_extend(input logic [OAW-1:0] v);
        return {{(IDW - OAW){v[OAW-1]}}, v};
    endfunction

    // Branch conditions look only at the flags registered before this edge.
    function automatic logic branch_taken(input logic [OPC_W-1:0] op, input logic z,
                                          input logic n);
        logic taken;
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = z;
            OP_BNE:  taken = !z;
            OP_BGT:  taken = !z && !n;
            OP_BGE:  taken = !n;
            OP_BLT:  taken = n;
            OP_BLE:  taken = n || z;
            OP_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    assign opcode  = instruction_in[IDW-1:OAW];
    assign operand = instruction_in[OAW-1:0];
    assign imm     = sign_extend(operand);
    assign mem_val = signed'(data_in);

    assign instruction_address_out = pc_q;
    assign data_address_out        = operand;
    assign data_out                = acc_q;
    assign data_wr_out             = (opcode == OP_STO) && !reset_in;

    always_comb begin
        alu_res = acc_q;
        alu_op  = 1'b0;
        case (opcode)
            OP_ADD:  begin alu_res = acc_q + mem_val; alu_op = 1'b1; end
            OP_ADDI: begin alu_res = acc_q + imm;     alu_op = 1'b1; end
            OP_SUB:  begin alu_res = acc_q - mem_val; alu_op = 1'b1; end
            OP_SUBI: begin alu_res = acc_q - imm;     alu_op = 1'b1; end
            default: begin alu_res = acc_q;           alu_op = 1'b0; end
        endcase
    end

    always_comb begin
        pc_nxt  = pc_q + OAW'(1);
        acc_nxt = acc_q;
        z_nxt   = z_q;
        n_nxt   = n_q;
        case (opcode)
            OP_HLT: pc_nxt = pc_q;
            OP_LD:  acc_nxt = mem_val;
            OP_LDI: acc_nxt = imm;
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                acc_nxt = alu_res;
                z_nxt   = (alu_res == '0);
                n_nxt   = alu_res[IDW-1];
            end
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
                if (branch_taken(opcode, z_q, n_q)) begin
                    pc_nxt = operand;
                end
            end
            default: ;
        endcase
        if (!alu_op) begin
            z_nxt = z_nxt;
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            pc_q  <= '0;
            acc_q <= '0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
        end else begin
            pc_q  <= pc_nxt;
            acc_q <= acc_nxt;
            z_q   <= z_nxt;
            n_q   <= n_nxt;
        end
    end

endmodule

// File: tb/tb_bip2_core.sv
// Bench for bip2_core: directed program scenarios followed by random instruction
// streams, all compared against an arithmetic model of the instruction set.
module tb_bip2_core;

    logic        clk;
    logic        reset_in;
    logic [15:0] instruction_in;
    logic [15:0] data_in;
    logic [10:0] instruction_address_out;
    logic [10:0] data_address_out;
    logic [15:0] data_out;
    logic        data_wr_out;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state, held as plain integers
    int m_pc  = 0;
    int m_acc = 0;
    bit m_z   = 0;
    bit m_n   = 0;
    bit m_known = 0;

    bip2_core #(
        .OPERAND_ADDRESS_WIDTH (11),
        .INSTRUCTION_DATA_WIDTH(16)
    ) dut (
        .clock_in               (clk),
        .reset_in               (reset_in),
        .instruction_in         (instruction_in),
        .data_in                (data_in),
        .instruction_address_out(instruction_address_out),
        .data_address_out       (data_address_out),
        .data_out               (data_out),
        .data_wr_out            (data_wr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int operand);
        logic [15:0] w;
        w = {op[4:0], operand[10:0]};
        return w;
    endfunction

    task automatic model(input logic [15:0] ins, input logic [15:0] din, input logic rst);
        int op, opd, imm, res;
        bit take;
        op  = int'(ins[15:11]);
        opd = int'(ins[10:0]);
        imm = (opd >= 1024) ? opd - 2048 : opd;
        if (rst) begin
            m_pc = 0; m_acc = 0; m_z = 0; m_n = 0; m_known = 1;
            return;
        end
        if (op >= 8 && op <= 14) begin
            case (op)
                8:  take = m_z;
                9:  take = !m_z;
                10: take = !m_z && !m_n;
                11: take = !m_n;
                12: take = m_n;
                13: take = m_n || m_z;
                default: take = 1;
            endcase
            m_pc = take ? opd : (m_pc + 1) % 2048;
            return;
        end
        if (op == 0) return;
        m_pc = (m_pc + 1) % 2048;
        if (op >= 4 && op <= 7) begin
            case (op)
                4: res = m_acc + int'(din);
                5: res = m_acc + imm;
                6: res = m_acc - int'(din);
                default: res = m_acc - imm;
            endcase
            res   = ((res % 65536) + 65536) % 65536;
            m_acc = res;
            m_z   = (res == 0);
            m_n   = (res >= 32768);
        end else if (op == 2) begin
            m_acc = int'(din);
        end else if (op == 3) begin
            m_acc = (imm + 65536) % 65536;
        end
    endtask

    task automatic step(input logic [15:0] ins, input logic [15:0] din, input logic rst);
        @(negedge clk);
        instruction_in = ins;
        data_in        = din;
        reset_in       = rst;
        #1;
        chk("daddr", 32'(data_address_out), 32'(ins[10:0]));
        chk("dwr", 32'(data_wr_out), 32'((ins[15:11] == 5'd1) && !rst));
        if (m_known) begin
            chk("iaddr_pre", 32'(instruction_address_out), 32'(m_pc));
            chk("dout_pre", 32'(data_out), 32'(m_acc));
        end
        @(posedge clk);
        model(ins, din, rst);
        #1;
        chk("pc", 32'(instruction_address_out), 32'(m_pc));
        chk("acc", 32'(data_out), 32'(m_acc));
    endtask

    initial begin
        reset_in       = 1'b1;
        instruction_in = '0;
        data_in        = '0;

        // Reset, LDI 5, ADDI 3
        step(mk(3, 0), 16'h0, 1'b1);
        step(mk(3, 0), 16'h0, 1'b1);
        chk("rst_pc", 32'(instruction_address_out), 32'h0);
        chk("rst_acc", 32'(data_out), 32'h0);
        step(mk(3, 5), 16'h0, 1'b0);
        step(mk(5, 3), 16'h0, 1'b0);
        chk("s1_acc", 32'(data_out), 32'd8);
        chk("s1_pc", 32'(instruction_address_out), 32'd2);
        step(mk(10, 4), 16'h0, 1'b0);
        chk("s1_bgt", 32'(instruction_address_out), 32'd4);

        // STO 0x001 with ACC=8
        step(mk(1, 1), 16'h0, 1'b0);
        chk("sto_acc", 32'(data_out), 32'd8);
        chk("sto_pc", 32'(instruction_address_out), 32'd5);

        // LD 8, SUB 8 -> zero; BEQ taken, BNE falls through
        step(mk(2, 3), 16'd8, 1'b0);
        step(mk(6, 3), 16'd8, 1'b0);
        chk("sub_acc", 32'(data_out), 32'd0);
        step(mk(8, 9), 16'h0, 1'b0);
        chk("beq_pc", 32'(instruction_address_out), 32'h009);
        step(mk(9, 9), 16'h0, 1'b0);
        chk("bne_pc", 32'(instruction_address_out), 32'h00A);

        // LDI -1, ADDI 0 -> N; BLT taken; 0x7FFF + 1 -> 0x8000
        step(mk(3, 11'h7FF), 16'h0, 1'b0);
        chk("ldi_neg", 32'(data_out), 32'hFFFF);
        step(mk(5, 0), 16'h0, 1'b0);
        step(mk(12, 12), 16'h0, 1'b0);
        chk("blt_pc", 32'(instruction_address_out), 32'h00C);
        step(mk(2, 0), 16'h7FFF, 1'b0);
        step(mk(5, 1), 16'h0, 1'b0);
        chk("ovf_acc", 32'(data_out), 32'h8000);
        step(mk(13, 11'h20), 16'h0, 1'b0);
        chk("ble_pc", 32'(instruction_address_out), 32'h020);

        // HLT held three edges, then opcode 11111
        repeat (3) step(mk(0, 0), 16'h0, 1'b0);
        chk("hlt_pc", 32'(instruction_address_out), 32'h020);
        chk("hlt_acc", 32'(data_out), 32'h8000);
        step(mk(31, 11'h555), 16'h1234, 1'b0);
        chk("nop_pc", 32'(instruction_address_out), 32'h021);
        chk("nop_acc", 32'(data_out), 32'h8000);

        // Reset mid-program while a store is presented
        step(mk(1, 2), 16'h0, 1'b1);
        chk("mrst_pc", 32'(instruction_address_out), 32'h0);
        chk("mrst_acc", 32'(data_out), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step(mk(31, 0), 16'h0, 1'b0);
            chk("resume_pc", 32'(instruction_address_out), 32'(i));
        end

        // Wrap of PC from 0x7FF
        step(mk(14, 11'h7FF), 16'h0, 1'b0);
        step(mk(3, 1), 16'h0, 1'b0);
        chk("wrap_pc", 32'(instruction_address_out), 32'h000);

        // Random instruction streams
        for (int i = 0; i < 2000; i++) begin
            logic [15:0] ins, din;
            logic        rst;
            int          op;
            op  = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 31) : $urandom_range(0, 14);
            ins = mk(op, $urandom_range(0, 2047));
            din = 16'($urandom());
            if ($urandom_range(0, 3) == 0)
                din = 16'($urandom_range(0, 3));
            rst = ($urandom_range(0, 99) == 0);
            step(ins, din, rst);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bip2_core.md
BIP2_CORE -- requirements
Module: bip2_core

Interface
REQ-001 Parameter OPERAND_ADDRESS_WIDTH, default 11, SHALL set the operand field, PC, instruction address and data address width.
REQ-002 Parameter INSTRUCTION_DATA_WIDTH, default 16, SHALL set the instruction width and the data width (ACC, data_in, data_out).
REQ-003 The block uses one clock; reset is synchronous and active-high.
REQ-004 clock_in  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 reset_in  input  1  SHALL be the synchronous, active-high reset.
REQ-006 instruction_in  input  16  SHALL carry the instruction: [15:11] opcode, [10:0] operand.
REQ-007 data_in  input  16  SHALL carry the data-memory read value at data_address_out, valid in the same cycle.
REQ-008 instruction_address_out  output  11  SHALL equal PC.
REQ-009 data_address_out  output  11  SHALL equal instruction_in[10:0], combinationally.
REQ-010 data_out  output  16  SHALL equal ACC.
REQ-011 data_wr_out  output  1  SHALL be 1 only when the opcode is STO and reset_in is 0.

Function
REQ-012 The processor SHALL be single-cycle Harvard: each rising edge completes one instruction, with no stall or handshake.
REQ-013 State SHALL be PC (11b), ACC (16b) and STATUS {Z, N}.
REQ-014 Immediate operands SHALL be the 11-bit operand sign-extended to 16 bits (imm).
REQ-015 The opcode map SHALL be:
- 00000 HLT: PC held; ACC/STATUS held.
- 00001 STO: mem[op] <= ACC via data_wr_out=1; ACC held.
- 00010 LD: ACC <= data_in.
- 00011 LDI: ACC <= imm.
- 00100 ADD: ACC <= ACC + data_in.
- 00101 ADDI: ACC <= ACC + imm.
- 00110 SUB: ACC <= ACC - data_in.
- 00111 SUBI: ACC <= ACC - imm.
REQ-016 Branch opcodes SHALL set PC <= operand if their condition holds, else PC <= PC+1:
- 01000 BEQ: Z.
- 01001 BNE: !Z.
- 01010 BGT: !Z & !N.
- 01011 BGE: !N.
- 01100 BLT: N.
- 01101 BLE: N | Z.
- 01110 JMP: always.
REQ-017 Every non-HLT, non-taken-branch instruction SHALL set PC <= PC+1, wrapping 0x7FF -> 0x000.
REQ-018 Arithmetic SHALL be modulo 2^16 with no overflow or carry flag.
REQ-019 Only ADD, ADDI, SUB and SUBI SHALL update STATUS: Z <= (result == 0), N <= result[15]. All other opcodes SHALL hold STATUS.
REQ-020 Branches SHALL test STATUS as registered before the current edge.
REQ-021 Opcodes 01111-11111 SHALL act as NOP: PC <= PC+1, no other state change, data_wr_out=0.
REQ-022 HLT SHALL persist until instruction_in changes or reset is applied; there is no latched halt state.

Reset
REQ-023 reset_in=1 at a rising edge SHALL set PC=0, ACC=0, Z=0 and N=0, overriding the current instruction.
REQ-024 While reset_in=1, data_wr_out SHALL be 0. Other outputs SHALL follow REQ-008 to REQ-010.
REQ-025 Reset asserted mid-program SHALL take effect at the next edge. Execution SHALL resume from PC=0 on the first edge with reset_in=0.

Verification
REQ-026 The bench SHALL cover these scenarios:
- Reset, then LDI 5, then ADDI 3 -> ACC=8, Z=0, N=0, PC=2.
- STO 0x001 with ACC=8 -> data_wr_out=1, data_address_out=0x001, data_out=8; ACC unchanged; PC+1.
- LD with data_in=8, then SUB with data_in=8 -> ACC=0, Z=1. Then BEQ 0x009 -> PC=0x009. BNE 0x009 in the same state -> PC+1.
- LDI 0x7FF (-1), then ADDI 0 -> N=1. Then BLT 0x00C -> PC=0x00C. ACC=0x7FFF plus ADDI 1 -> ACC=0x8000, N=1.
- HLT held for 3 edges -> PC and ACC unchanged. Opcode 11111 -> PC+1 only.
- Reset asserted mid-program -> PC=0, ACC=0, data_wr_out=0 during reset. PC counts 0, 1, 2 after release.
